lcd_32_to_8_bits_dfa_unpacker: RTL and testbench

LCD_32_TO_8_BITS_DFA_UNPACKER -- requirements
Module: lcd_32_to_8_bits_dfa_unpacker

---
 rtl/lcd_dfa_pkg.sv | 17 +
 rtl/lcd_32_to_8_bits_dfa_unpacker_if.sv | 28 ++
 rtl/lcd_32_to_8_bits_dfa_state_ram.sv | 45 ++++
 rtl/lcd_32_to_8_bits_dfa_unpacker.sv | 99 +++++++++
 tb/tb_lcd_32_to_8_bits_dfa_unpacker.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_dfa_pkg.sv
// rtl/lcd_dfa_pkg.sv - shared widths and big-endian symbol select for the 32-to-8 unpacker
package lcd_dfa_pkg;

  localparam int SYMBOL_WIDTH = 8;
  localparam int IN_SYMBOLS   = 4;
  localparam int EMPTY_WIDTH  = $clog2(IN_SYMBOLS);
  localparam int DATA_WIDTH   = SYMBOL_WIDTH * IN_SYMBOLS;

  // Symbol 0 lives in the most significant lane of the word.
  function automatic logic [SYMBOL_WIDTH-1:0] sym_select(
    input logic [DATA_WIDTH-1:0]  word,
    input logic [EMPTY_WIDTH-1:0] idx
  );
    return word[(IN_SYMBOLS - 1 - int'(idx)) * SYMBOL_WIDTH +: SYMBOL_WIDTH];
  endfunction

endpackage

// File: rtl/lcd_32_to_8_bits_dfa_unpacker_if.sv
// rtl/lcd_32_to_8_bits_dfa_unpacker_if.sv - word-in / symbol-out stream bundle
interface lcd_32_to_8_bits_dfa_unpacker_if;
  import lcd_dfa_pkg::*;

  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_startofpacket;
  logic                    in_endofpacket;
  logic [EMPTY_WIDTH-1:0]  in_empty;

  logic [SYMBOL_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_startofpacket;
  logic                    out_endofpacket;

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket
  );

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket
  );

endinterface

// File: rtl/lcd_32_to_8_bits_dfa_state_ram.sv
// rtl/lcd_32_to_8_bits_dfa_state_ram.sv - single-entry state RAM holding the unpacker byte index
module lcd_32_to_8_bits_dfa_state_ram #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_write,
  output logic                  wr_waitrequest,
  input  logic [ADDR_WIDTH-1:0] rd0_address,
  output logic [DATA_WIDTH-1:0] rd0_data
);

  logic [DATA_WIDTH-1:0] mem_q, mem_d;
  logic                  wait_q, wait_d;

  // Only location 0 exists; writes elsewhere are dropped, and writes are refused while busy.
  always_comb begin
    mem_d  = mem_q;
    wait_d = 1'b0;
    if (wr_write && !wait_q && (wr_address == '0)) begin
      mem_d = wr_data;
    end
  end

  // The RAM stays busy from reset until the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q  <= '0;
      wait_q <= 1'b1;
    end else begin
      mem_q  <= mem_d;
      wait_q <= wait_d;
    end
  end

  // Lookahead read: a write committed at the end of cycle k-1 is what rd0 shows in cycle k.
  always_comb begin
    rd0_data       = (rd0_address == '0) ? mem_q : '0;
    wr_waitrequest = wait_q;
  end

endmodule

// File: rtl/lcd_32_to_8_bits_dfa_unpacker.sv
// rtl/lcd_32_to_8_bits_dfa_unpacker.sv - splits 32-bit packet words into big-endian 8-bit symbols
module lcd_32_to_8_bits_dfa_unpacker #(
  parameter int SYMBOL_WIDTH = lcd_dfa_pkg::SYMBOL_WIDTH,
  parameter int IN_SYMBOLS   = lcd_dfa_pkg::IN_SYMBOLS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  lcd_32_to_8_bits_dfa_unpacker_if.slave bus
);
  import lcd_dfa_pkg::*;

  localparam int EMPTY_WIDTH = $clog2(IN_SYMBOLS);
  localparam int DATA_WIDTH  = SYMBOL_WIDTH * IN_SYMBOLS;
  localparam logic [EMPTY_WIDTH-1:0] LAST_SYM = EMPTY_WIDTH'(IN_SYMBOLS - 1);

  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic [EMPTY_WIDTH-1:0] empty_q, empty_d;
  logic                   word_valid_q, word_valid_d;

  logic [EMPTY_WIDTH-1:0] idx;
  logic [EMPTY_WIDTH-1:0] idx_next;
  logic [EMPTY_WIDTH-1:0] last_idx;
  logic                   at_last;
  logic                   wr_waitrequest;
  logic                   in_xfer;
  logic                   out_xfer;

  // Byte index lives in the state RAM; location 0 is written on every emitted symbol.
  lcd_32_to_8_bits_dfa_state_ram #(
    .DATA_WIDTH (EMPTY_WIDTH),
    .ADDR_WIDTH (1)
  ) u_state_ram (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_address     (1'b0),
    .wr_data        (idx_next),
    .wr_write       (out_xfer),
    .wr_waitrequest (wr_waitrequest),
    .rd0_address    (1'b0),
    .rd0_data       (idx)
  );

  // Last symbol of the buffered word (empty only trims the final word) and the index step.
  always_comb begin
    last_idx = eop_q ? (LAST_SYM - empty_q) : LAST_SYM;
    at_last  = (idx == last_idx);
    idx_next = at_last ? '0 : idx + EMPTY_WIDTH'(1);
    out_xfer = word_valid_q && bus.out_ready;
    // Accept a new word when the buffer is free or is emitting its final symbol this cycle.
    bus.in_ready = (!word_valid_q || (bus.out_ready && at_last)) && !wr_waitrequest;
    in_xfer      = bus.in_valid && bus.in_ready;
  end

  // Word buffer: load on accept, retire after the last symbol leaves.
  always_comb begin
    word_d       = word_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    empty_d      = empty_q;
    word_valid_d = word_valid_q;
    if (in_xfer) begin
      word_d       = bus.in_data;
      sop_d        = bus.in_startofpacket;
      eop_d        = bus.in_endofpacket;
      empty_d      = bus.in_endofpacket ? bus.in_empty : '0;
      word_valid_d = 1'b1;
    end else if (out_xfer && at_last) begin
      word_valid_d = 1'b0;
    end
  end

  // Buffer registers; reset discards any partially emitted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q       <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_q       <= word_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      empty_q      <= empty_d;
      word_valid_q <= word_valid_d;
    end
  end

  // Output symbol and framing come straight from the buffer and the current index.
  always_comb begin
    bus.out_valid         = word_valid_q;
    bus.out_data          = sym_select(word_q, idx);
    bus.out_startofpacket = sop_q && (idx == '0);
    bus.out_endofpacket   = eop_q && at_last;
  end

endmodule

// File: tb/tb_lcd_32_to_8_bits_dfa_unpacker.sv
// tb/tb_lcd_32_to_8_bits_dfa_unpacker.sv - randomized and directed bench with a symbol-queue reference model
module tb_lcd_32_to_8_bits_dfa_unpacker;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lcd_32_to_8_bits_dfa_unpacker_if bus ();

  lcd_32_to_8_bits_dfa_unpacker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } sym_t;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [1:0]  m;
  } word_t;

  sym_t  exp_q[$];
  word_t stim_q[$];
  bit    or_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    wait_m = 1'b1;
  int    gap_pct = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A word expands to 4 symbols, fewer only when it ends a packet.
  function automatic void push_word(input word_t w);
    int n;
    logic [31:0] d;
    n = w.e ? 4 - int'(w.m) : 4;
    d = w.d;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{d: d[8*(3-i) +: 8], s: w.s && (i == 0), e: w.e && (i == n - 1)});
    end
  endfunction

  function automatic void add_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    stim_q.push_back('{d: d, s: s, e: e, m: m});
  endfunction

  task automatic drive(input bit fired);
    if (!(bus.in_valid && !fired)) begin
      if (stim_q.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
        bus.in_valid         = 1'b1;
        bus.in_data          = stim_q[0].d;
        bus.in_startofpacket = stim_q[0].s;
        bus.in_endofpacket   = stim_q[0].e;
        bus.in_empty         = stim_q[0].m;
      end else begin
        bus.in_valid         = 1'b0;
        bus.in_data          = $urandom;
        bus.in_startofpacket = 1'($urandom_range(1));
        bus.in_endofpacket   = 1'($urandom_range(1));
        bus.in_empty         = 2'($urandom_range(3));
      end
    end
    if (or_q.size() != 0) bus.out_ready = or_q.pop_front();
    else if (rand_ready)  bus.out_ready = 1'($urandom_range(1));
    else                  bus.out_ready = 1'b1;
  endtask

  task automatic cycle();
    bit in_fire;
    bit out_fire;
    bit exp_ready;
    @(negedge clk);
    exp_ready = (exp_q.size() == 0 || (bus.out_ready && exp_q.size() == 1)) && !wait_m;
    check("in_ready", bus.in_ready, exp_ready);
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_data", bus.out_data, exp_q[0].d);
      check("out_sop", bus.out_startofpacket, exp_q[0].s);
      check("out_eop", bus.out_endofpacket, exp_q[0].e);
    end
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    @(posedge clk);
    wait_m = 1'b0;
    if (out_fire && exp_q.size() != 0) void'(exp_q.pop_front());
    if (in_fire && stim_q.size() != 0) begin
      push_word(stim_q[0]);
      void'(stim_q.pop_front());
    end
    #1;
    drive(in_fire);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    wait_m = 1'b1;
    #1;
    check("rst_out_valid_async", bus.out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_out_sop", bus.out_startofpacket, 1'b0);
    check("rst_out_eop", bus.out_endofpacket, 1'b0);
    reset_n = 1'b1;
    drive(1'b1);
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    drive(1'b1);
    while ((stim_q.size() != 0 || exp_q.size() != 0 || or_q.size() != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    check("idle_timeout", n < max_cycles, 1'b1);
    repeat (2) cycle();
  endtask

  initial begin
    reset_n              = 1'b0;
    bus.in_valid         = 1'b0;
    bus.in_data          = '0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket   = 1'b0;
    bus.in_empty         = '0;
    bus.out_ready        = 1'b0;
    @(posedge clk);
    do_reset();

    // single full word
    add_word(32'h11223344, 1'b1, 1'b1, 2'd0);
    run_until_idle(50);

    // back-to-back words, no bubble
    add_word(32'hA1A2A3A4, 1'b1, 1'b0, 2'd0);
    add_word(32'hB1B2B3B4, 1'b0, 1'b1, 2'd0);
    run_until_idle(50);

    // trimmed final words
    add_word(32'hDEADBEEF, 1'b1, 1'b1, 2'd3);
    add_word(32'hDEADBEEF, 1'b1, 1'b1, 2'd1);
    run_until_idle(50);

    // empty ignored without eop
    add_word(32'hCAFEF00D, 1'b1, 1'b0, 2'd3);
    add_word(32'h0BADF00D, 1'b0, 1'b1, 2'd2);
    run_until_idle(50);

    // stall on the second symbol
    add_word(32'h01020304, 1'b1, 1'b1, 2'd0);
    or_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_until_idle(50);

    // reset mid-packet after the first symbol
    add_word(32'h55667788, 1'b1, 1'b1, 2'd0);
    drive(1'b1);
    cycle();
    cycle();
    do_reset();
    add_word(32'h99AABBCC, 1'b1, 1'b1, 2'd0);
    run_until_idle(50);

    // randomized traffic with gaps and back-pressure
    gap_pct    = 30;
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      add_word($urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)));
    end
    run_until_idle(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
